// File: rtl/handle_table.sv
// handle_table: handle-to-region translation table with allocate, free,
// translate and flush commands over a valid/ready request/response pair.
// Each entry holds {valid, base, limit}. Every translation is bounds-checked.

// One table entry. A scrub clear wins over everything else. FREE drops only
// the valid bit, so a freed entry keeps stale base/limit until it is
// reallocated or scrubbed.
module handle_cell #(
    parameter int OFFS_WIDTH = 48
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  set,
    input  logic                  free_clr,
    input  logic                  scrub_clr,
    input  logic [OFFS_WIDTH-1:0] base_in,
    input  logic [OFFS_WIDTH-1:0] limit_in,
    output logic                  valid,
    output logic [OFFS_WIDTH-1:0] base,
    output logic [OFFS_WIDTH-1:0] limit
);

    // Entry storage: scrub > alloc > free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            base  <= '0;
            limit <= '0;
        end else if (scrub_clr) begin
            valid <= 1'b0;
            base  <= '0;
            limit <= '0;
        end else if (set) begin
            valid <= 1'b1;
            base  <= base_in;
            limit <= limit_in;
        end else if (free_clr) begin
            valid <= 1'b0;
        end
    end

endmodule

module handle_table #(
    parameter int ADDR_WIDTH = 64,
    parameter int HNDL_WIDTH = 15,
    parameter int NUM_CELLS  = 32,
    parameter int OFFS_WIDTH = ADDR_WIDTH - HNDL_WIDTH - 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [OFFS_WIDTH-1:0] req_base,
    input  logic [OFFS_WIDTH-1:0] req_limit,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [1:0]            rsp_status,
    output logic [HNDL_WIDTH:0]   free_count
);

    localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam logic [HNDL_WIDTH:0] CELLS_CNT = (HNDL_WIDTH+1)'(NUM_CELLS);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_CELLS - 1);

    localparam logic [1:0] OP_TRANSLATE = 2'd0;
    localparam logic [1:0] OP_ALLOC     = 2'd1;
    localparam logic [1:0] OP_FREE      = 2'd2;
    localparam logic [1:0] OP_FLUSH     = 2'd3;

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_INVALID   = 2'd1;
    localparam logic [1:0] ST_BOUNDS    = 2'd2;
    localparam logic [1:0] ST_FULL      = 2'd3;

    typedef enum logic [0:0] {IDLE, SCRUB} state_t;

    state_t state, state_nxt;
    logic [IDX_W-1:0] scrub_idx;

    logic [NUM_CELLS-1:0]                 cell_valid;
    logic [NUM_CELLS-1:0][OFFS_WIDTH-1:0] cell_base;
    logic [NUM_CELLS-1:0][OFFS_WIDTH-1:0] cell_limit;

    // Request address fields.
    logic                  req_flag;
    logic [HNDL_WIDTH-1:0] req_hndl;
    logic [OFFS_WIDTH-1:0] req_offs;
    logic [IDX_W-1:0]      hidx;
    logic                  hndl_ok;
    logic                  hit;
    logic [OFFS_WIDTH-1:0] sel_base;
    logic [OFFS_WIDTH-1:0] sel_limit;
    logic [OFFS_WIDTH-1:0] xlat_sum;

    assign req_flag  = req_addr[ADDR_WIDTH-1];
    assign req_hndl  = req_addr[ADDR_WIDTH-2:OFFS_WIDTH];
    assign req_offs  = req_addr[OFFS_WIDTH-1:0];
    assign hidx      = req_hndl[IDX_W-1:0];
    assign hndl_ok   = {1'b0, req_hndl} < CELLS_CNT;
    // Only meaningful when hndl_ok; out-of-range handles never reach the table.
    assign hit       = hndl_ok && cell_valid[hidx];
    assign sel_base  = cell_base[hidx];
    assign sel_limit = cell_limit[hidx];
    assign xlat_sum  = sel_base + req_offs;

    // Handshake: single output register, so accept only when it is free or draining.
    logic accept, do_alloc, do_free, scrub_last;
    assign req_ready  = (state == IDLE) && (!rsp_valid || rsp_ready);
    assign accept     = req_valid && req_ready;
    assign scrub_last = (state == SCRUB) && (scrub_idx == LAST_IDX);

    // Lowest-index free entry (scan from the top so the lowest wins).
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (!cell_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign do_alloc = accept && (req_op == OP_ALLOC) && free_found;
    assign do_free  = accept && (req_op == OP_FREE) && hit;

    // Response value for a non-flush request accepted this cycle.
    logic [1:0]            nxt_status;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    always_comb begin
        nxt_status = ST_OK;
        nxt_addr   = '0;
        case (req_op)
            OP_TRANSLATE: begin
                if (!req_flag) begin
                    nxt_addr = req_addr;
                end else if (!hit) begin
                    nxt_status = ST_INVALID;
                end else if (req_offs >= sel_limit) begin
                    nxt_status = ST_BOUNDS;
                end else begin
                    nxt_addr = {{(ADDR_WIDTH-OFFS_WIDTH){1'b0}}, xlat_sum};
                end
            end
            OP_ALLOC: begin
                if (free_found) begin
                    nxt_addr = {1'b1, HNDL_WIDTH'(free_idx), {OFFS_WIDTH{1'b0}}};
                end else begin
                    nxt_status = ST_FULL;
                end
            end
            OP_FREE: begin
                if (hit) begin
                    nxt_addr = req_addr;
                end else begin
                    nxt_status = ST_INVALID;
                end
            end
            default: begin
                nxt_status = ST_OK;
                nxt_addr   = '0;
            end
        endcase
    end

    // Table entries.
    for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
        handle_cell #(.OFFS_WIDTH(OFFS_WIDTH)) u_cell (
            .clock     (clock),
            .reset_n   (reset_n),
            .set       (do_alloc && (free_idx == IDX_W'(g))),
            .free_clr  (do_free && (hidx == IDX_W'(g))),
            .scrub_clr ((state == SCRUB) && (scrub_idx == IDX_W'(g))),
            .base_in   (req_base),
            .limit_in  (req_limit),
            .valid     (cell_valid[g]),
            .base      (cell_base[g]),
            .limit     (cell_limit[g])
        );
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next state: FLUSH walks every entry once, then returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && (req_op == OP_FLUSH)) state_nxt = SCRUB;
            SCRUB:   if (scrub_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Scrub index: entry i is cleared on the i-th cycle spent in SCRUB.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)           scrub_idx <= '0;
        else if (scrub_last)    scrub_idx <= '0;
        else if (state == SCRUB) scrub_idx <= scrub_idx + IDX_W'(1);
    end

    // Free-entry counter tracks the number of invalid entries.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            free_count <= CELLS_CNT;
        else if (state == SCRUB)
            free_count <= free_count + {{HNDL_WIDTH{1'b0}}, cell_valid[scrub_idx]};
        else if (do_alloc)
            free_count <= free_count - (HNDL_WIDTH+1)'(1);
        else if (do_free)
            free_count <= free_count + (HNDL_WIDTH+1)'(1);
    end

    // Output register: load on accept or at end of scrub, else drain on rsp_ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid  <= 1'b0;
            rsp_addr   <= '0;
            rsp_status <= ST_OK;
        end else if (accept && (req_op != OP_FLUSH)) begin
            rsp_valid  <= 1'b1;
            rsp_addr   <= nxt_addr;
            rsp_status <= nxt_status;
        end else if (scrub_last) begin
            rsp_valid  <= 1'b1;
            rsp_addr   <= '0;
            rsp_status <= ST_OK;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_handle_table.sv
// Randomised scoreboard bench for handle_table: expected responses come from
// an array-based model of the table and are compared by a separate monitor.
module tb_handle_table;

    localparam int AW = 64;
    localparam int HW = 15;
    localparam int NC = 32;
    localparam int OW = AW - HW - 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'd0;
    logic [AW-1:0] req_addr = '0;
    logic [OW-1:0] req_base = '0;
    logic [OW-1:0] req_limit = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [AW-1:0] rsp_addr;
    logic [1:0]    rsp_status;
    logic [HW:0]   free_count;

    handle_table #(.ADDR_WIDTH(AW), .HNDL_WIDTH(HW), .NUM_CELLS(NC)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_base(req_base), .req_limit(req_limit),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_status(rsp_status), .free_count(free_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit rand_bp = 1'b0;

    // Reference model: plain arrays of entries.
    bit            m_valid [NC];
    logic [OW-1:0] m_base  [NC];
    logic [OW-1:0] m_limit [NC];
    logic [65:0]   exp_q[$];

    function automatic int model_free();
        int n = 0;
        for (int i = 0; i < NC; i++) if (!m_valid[i]) n++;
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NC; i++) begin
            m_valid[i] = 1'b0; m_base[i] = '0; m_limit[i] = '0;
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [OW-1:0] b, input logic [OW-1:0] l,
                         output logic [1:0] st, output logic [AW-1:0] ra);
        int h;
        int slot;
        logic [OW-1:0] off;
        logic [OW-1:0] sum;
        h   = int'(a[AW-2:OW]);
        off = a[OW-1:0];
        st  = 2'd0;
        ra  = '0;
        case (op)
            2'd0: begin
                if (!a[AW-1]) ra = a;
                else if (h >= NC) st = 2'd1;
                else if (!m_valid[h]) st = 2'd1;
                else if (off >= m_limit[h]) st = 2'd2;
                else begin sum = m_base[h] + off; ra = {16'h0, sum}; end
            end
            2'd1: begin
                slot = -1;
                for (int i = NC - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
                if (slot < 0) st = 2'd3;
                else begin
                    m_valid[slot] = 1'b1; m_base[slot] = b; m_limit[slot] = l;
                    ra = {1'b1, HW'(slot), {OW{1'b0}}};
                end
            end
            2'd2: begin
                if (h < NC && m_valid[h]) begin m_valid[h] = 1'b0; ra = a; end
                else st = 2'd1;
            end
            default: model_clear();
        endcase
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] haddr(input int h, input logic [OW-1:0] off);
        return {1'b1, HW'(h), off};
    endfunction

    // Drive one request, wait (bounded) for acceptance, then record its expectation.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [OW-1:0] b, input logic [OW-1:0] l);
        int n = 0;
        logic [1:0] st;
        logic [AW-1:0] ra;
        req_valid = 1'b1; req_op = op; req_addr = a; req_base = b; req_limit = l;
        while (!req_ready && n < 300) begin @(negedge clock); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: op %0d never accepted", op);
            req_valid = 1'b0;
            return;
        end
        model(op, a, b, l, st, ra);
        exp_q.push_back({st, ra});
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(posedge clock); n++; end
        #1;
        reset_n = 1'b0;
        model_clear();
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Monitor: every response handshake pops one expectation.
    always @(negedge clock) begin
        logic [65:0] e;
        if (reset_n && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: status %0d addr %h with nothing expected", rsp_status, rsp_addr);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_status, rsp_addr} !== e) begin
                    errors++;
                    $display("FAIL rsp: got status %0d addr %h expected status %0d addr %h",
                             rsp_status, rsp_addr, e[65:64], e[63:0]);
                end
            end
        end
    end

    // Random consumer backpressure.
    always @(posedge clock) begin
        #1;
        if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        int n;
        int lows;
        logic [1:0] op;
        logic [AW-1:0] a;
        logic [OW-1:0] b, l;

        model_clear();
        repeat (3) @(negedge clock);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_addr", rsp_addr, 64'd0);
        check("reset_rsp_status", 64'(rsp_status), 64'd0);
        check("reset_free_count", 64'(free_count), 64'(NC));
        check("reset_req_ready", 64'(req_ready), 64'd1);
        reset_n = 1'b1;
        @(negedge clock);

        // Basic translate flow.
        issue(2'd1, '0, 48'h1000, 48'h100);
        check("alloc_free_count", 64'(free_count), 64'd31);
        issue(2'd0, 64'h8000_0000_0000_0020, '0, '0);
        issue(2'd0, 64'h8000_0000_0000_0100, '0, '0);
        issue(2'd0, 64'h0000_0000_0000_1234, '0, '0);

        // Fill the table, overflow, then free/realloc.
        do_reset();
        for (int i = 0; i < 33; i++) issue(2'd1, '0, OW'(i * 'h40), 48'h80);
        check("full_free_count", 64'(free_count), 64'd0);
        issue(2'd2, haddr(5, '0), '0, '0);
        issue(2'd1, '0, 48'h5000, 48'h10);
        issue(2'd2, haddr(7, '0), '0, '0);
        issue(2'd2, haddr(7, '0), '0, '0);
        issue(2'd0, haddr(40, 48'h4), '0, '0);
        issue(2'd0, haddr(5, 48'hf), '0, '0);
        check("after_free_count", 64'(free_count), 64'(model_free()));

        // Hold a response with rsp_ready low.
        @(posedge clock); #1; rsp_ready = 1'b0;
        issue(2'd0, 64'h0000_0000_0000_abcd, '0, '0);
        for (int i = 0; i < 3; i++) begin
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_rsp_addr", rsp_addr, 64'h0000_0000_0000_abcd);
            @(negedge clock);
        end
        @(posedge clock); #1; rsp_ready = 1'b1;

        // FLUSH timing with 4 valid entries.
        do_reset();
        for (int i = 0; i < 4; i++) issue(2'd1, '0, 48'h100, 48'h100);
        issue(2'd3, '0, '0, '0);
        lows = 0;
        for (int i = 0; i < NC; i++) begin
            if (!req_ready) lows++;
            @(negedge clock);
        end
        check("flush_ready_low", 64'(lows), 64'(NC));
        check("flush_rsp_valid", 64'(rsp_valid), 64'd1);
        check("flush_free_count", 64'(free_count), 64'(NC));
        issue(2'd0, haddr(0, 48'h0), '0, '0);

        // Reset in the middle of a scrub.
        do_reset();
        for (int i = 0; i < 20; i++) issue(2'd1, '0, 48'h200, 48'h20);
        issue(2'd3, '0, '0, '0);
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        model_clear();
        exp_q.delete();
        #1;
        check("midflush_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midflush_free_count", 64'(free_count), 64'(NC));
        check("midflush_req_ready", 64'(req_ready), 64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Randomised traffic with backpressure.
        rand_bp = 1'b1;
        for (int k = 0; k < 400; k++) begin
            n = $urandom_range(0, 99);
            op = (n < 40) ? 2'd0 : (n < 72) ? 2'd1 : (n < 97) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 3) != 0)
                a = haddr($urandom_range(0, 39), OW'($urandom_range(0, 'h2ff)));
            else
                a = {1'b0, 31'($urandom), 32'($urandom)};
            b = ($urandom_range(0, 7) == 0) ? 48'hffff_ffff_ff00 : {16'($urandom), 32'($urandom)};
            l = OW'($urandom_range(0, 'h300));
            issue(op, a, b, l);
            if (op != 2'd3) check("rand_free_count", 64'(free_count), 64'(model_free()));
        end
        rand_bp = 1'b0;
        @(posedge clock); #1; rsp_ready = 1'b1;

        n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clock); n++; end
        check("drain_pending", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/handle_table.md
# handle_table

Parametrised handle-translation table that maps object handles to bounded physical regions. It replaces the per-cell tri-state handle array with a single clocked block offering allocate, free, translate and flush commands over a valid/ready request/response interface. The block sits in front of virtual address translation. Each table entry stores a base, a limit and a valid bit, so every translation is bounds-checked.

## Interface
Parameters:
- ADDR_WIDTH, 64, full address width.
- HNDL_WIDTH, 15, handle field width.
- NUM_CELLS, 32, number of table entries; must satisfy 1 ≤ NUM_CELLS ≤ 2^HNDL_WIDTH.
- OFFS_WIDTH, ADDR_WIDTH-HNDL_WIDTH-1, derived; offset/base/limit width.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts request this cycle.
- req_op  in  2  0=TRANSLATE, 1=ALLOC, 2=FREE, 3=FLUSH.
- req_addr  in  ADDR_WIDTH  address (TRANSLATE) or handled address (FREE).
- req_base  in  OFFS_WIDTH  region base (ALLOC).
- req_limit  in  OFFS_WIDTH  region size in bytes (ALLOC).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_addr  out  ADDR_WIDTH  result address or handle.
- rsp_status  out  2  0=OK, 1=FAULT_INVALID, 2=FAULT_BOUNDS, 3=FULL.
- free_count  out  HNDL_WIDTH+1  number of invalid entries.

## Operation
- Address format: bit ADDR_WIDTH-1 = handled flag; bits [ADDR_WIDTH-2:OFFS_WIDTH] = handle h; bits [OFFS_WIDTH-1:0] = offset.
- TRANSLATE behaves as follows:
  - Flag 0: pass through; rsp_addr = req_addr, OK.
  - h ≥ NUM_CELLS or entry invalid: FAULT_INVALID, rsp_addr = 0.
  - offset ≥ limit: FAULT_BOUNDS, rsp_addr = 0.
  - Otherwise OK, rsp_addr = zero-extended (base+offset) mod 2^OFFS_WIDTH.
- ALLOC picks the lowest-index invalid entry, sets it valid and stores base and limit. It responds OK with rsp_addr = {1, h, OFFS_WIDTH zeros}. If no entry is free, it responds FULL with rsp_addr = 0 and the table is unchanged. limit = 0 is legal; every TRANSLATE to that entry then faults.
- FREE on a valid entry with h < NUM_CELLS clears its valid bit and responds OK with rsp_addr = req_addr. Otherwise it responds FAULT_INVALID. The handled flag is ignored for FREE.
- FLUSH enters state SCRUB and clears entry i on cycle i, for i = 0..NUM_CELLS-1. It then returns to IDLE and issues one OK response with rsp_addr = 0.
- FSM states:
  - IDLE: accepts requests.
  - SCRUB: index counter runs; req_ready = 0.
  - IDLE→SCRUB on an accepted FLUSH.
  - SCRUB→IDLE after the last entry is cleared. The response is loaded on that edge.
- free_count is a registered value: incremented on a successful FREE, decremented on a successful ALLOC, and incremented per valid entry cleared during SCRUB. It always equals the number of invalid entries.

## Timing
- Reset values:
  - rsp_valid 0, rsp_addr 0, rsp_status 0.
  - All valid bits 0, bases and limits 0.
  - free_count = NUM_CELLS; state IDLE; req_ready 1.
- req_ready = (state==IDLE) & (!rsp_valid | rsp_ready). It is combinational; there is a one-entry output register.
- A request is accepted on a rising edge when req_valid & req_ready. The table update and response register load happen on that same edge (latency 1 for non-FLUSH ops).
- FLUSH latency is NUM_CELLS+1 edges from accept to rsp_valid.
- Back-to-back requests are legal. An ALLOC followed next cycle by TRANSLATE/FREE of the new handle sees the new entry. Consecutive ALLOCs return distinct handles.
- rsp_valid, rsp_addr and rsp_status hold stable while rsp_valid & !rsp_ready.
- Reset asserted mid-operation (including SCRUB) immediately returns every register to its reset value. A pending response is discarded.
- Inputs other than req_valid are don't-care when no request is accepted.

## Test plan
- After reset, check free_count = 32 and req_ready = 1. Issue ALLOC base=0x1000 limit=0x100 → OK, rsp_addr=0x8000_0000_0000_0000, free_count=31.
- TRANSLATE 0x8000_0000_0000_0020 → OK, rsp_addr=0x1020. TRANSLATE 0x8000_0000_0000_0100 → FAULT_BOUNDS. TRANSLATE 0x0000_0000_0000_1234 → OK, rsp_addr=0x1234.
- Issue 33 back-to-back ALLOCs from reset → handles 0..31 in order, then FULL with free_count=0. FREE handle 5, then ALLOC → handle 5.
- FREE handle 7 twice → OK then FAULT_INVALID. TRANSLATE handle 40 → FAULT_INVALID.
- Hold rsp_ready=0 for 3 cycles → req_ready=0 and the response is held. FLUSH with 4 valid entries → req_ready low for 32 cycles, response on cycle 33, free_count=32.
- Assert reset_n=0 at cycle 10 of a FLUSH → rsp_valid=0, state IDLE, free_count=32 immediately.
